// File: rtl/led_strip_driver.sv
// led_strip_driver: serial driver for chains of WS2801-style clocked LED
// controllers. One pixel is accepted per valid/ready handshake, scaled by a
// global brightness, shifted out MSB-first on ledClock/ledData, and the frame
// ends with an idle-low latch interval followed by a one-cycle done pulse.
module led_strip_driver #(
    parameter int LEDS         = 50,
    parameter int CHANNELS     = 3,
    parameter int BPC          = 8,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 6250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BPC-1:0]          brightness,
    input  logic [CHANNELS*BPC-1:0] pixelData,
    input  logic                    pixelValid,
    output logic                    pixelReady,
    output logic                    ledClock,
    output logic                    ledData,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);

    localparam int NBITS   = CHANNELS * BPC;
    localparam int BIT_W   = $clog2(NBITS);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PIX_W   = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int LAT_W   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int HALF    = LATCH_CYCLES / 2;
    localparam int STALL_W = (HALF > 0) ? $clog2(HALF + 1) : 1;
    localparam int THR     = (HALF > 0) ? HALF - 1 : 0;

    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(LEDS - 1);
    localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(HALF);
    localparam logic [STALL_W-1:0] STALL_THR = STALL_W'(THR);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Each channel becomes (c * (scale + 1)) >> BPC; the 2*BPC-bit product
    // never overflows, so the upper half is the scaled channel directly.
    function automatic logic [NBITS-1:0] scale_word(input logic [NBITS-1:0] word,
                                                    input logic [BPC-1:0]   scale);
        logic [2*BPC-1:0] mult;
        logic [2*BPC-1:0] prod;
        logic [NBITS-1:0] res;
        res  = '0;
        mult = {{(BPC-1){1'b0}}, ({1'b0, scale} + {{BPC{1'b0}}, 1'b1})};
        for (int c = 0; c < CHANNELS; c++) begin
            prod = {{BPC{1'b0}}, word[c*BPC +: BPC]} * mult;
            res[c*BPC +: BPC] = prod[2*BPC-1:BPC];
        end
        return res;
    endfunction

    state_t             r_state;
    logic [BPC-1:0]     r_breg;
    logic [NBITS-1:0]   r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_high;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [LAT_W-1:0]   r_latch_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_pixel_ready;
    logic               r_led_clock;
    logic               r_led_data;
    logic               r_busy;
    logic               r_done;
    logic               r_underrun;
    logic [NBITS-1:0]   w_scaled;

    assign w_scaled   = scale_word(pixelData, r_breg);
    assign pixelReady = r_pixel_ready;
    assign ledClock   = r_led_clock;
    assign ledData    = r_led_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign underrun   = r_underrun;

    // Frame sequencer: fetch, serialise, latch, done; all outputs registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_breg        <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_div_cnt     <= '0;
            r_high        <= 1'b0;
            r_pix_cnt     <= '0;
            r_latch_cnt   <= '0;
            r_stall_cnt   <= '0;
            r_pixel_ready <= 1'b0;
            r_led_clock   <= 1'b0;
            r_led_data    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_breg        <= brightness;
                        r_pix_cnt     <= '0;
                        r_stall_cnt   <= '0;
                        r_underrun    <= 1'b0;
                        r_busy        <= 1'b1;
                        r_pixel_ready <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_led_clock <= 1'b0;
                    if (pixelValid && r_pixel_ready) begin
                        r_shift       <= w_scaled;
                        r_led_data    <= w_scaled[NBITS-1];
                        r_pixel_ready <= 1'b0;
                        r_bit_cnt     <= '0;
                        r_div_cnt     <= '0;
                        r_high        <= 1'b0;
                        r_stall_cnt   <= '0;
                        r_state       <= ST_SHIFT;
                    end else begin
                        // Stall: the strip may latch on its own, so flag it.
                        if (r_stall_cnt != STALL_MAX) begin
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                        end
                        if (r_stall_cnt >= STALL_THR) begin
                            r_underrun <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        if (!r_high) begin
                            r_high      <= 1'b1;
                            r_led_clock <= 1'b1;
                        end else begin
                            r_high      <= 1'b0;
                            r_led_clock <= 1'b0;
                            if (r_bit_cnt == BIT_LAST) begin
                                if (r_pix_cnt == PIX_LAST) begin
                                    r_led_data  <= 1'b0;
                                    r_latch_cnt <= '0;
                                    r_state     <= ST_LATCH;
                                end else begin
                                    r_pix_cnt     <= r_pix_cnt + 1'b1;
                                    r_pixel_ready <= 1'b1;
                                    r_state       <= ST_FETCH;
                                end
                            end else begin
                                r_bit_cnt  <= r_bit_cnt + 1'b1;
                                r_shift    <= r_shift << 1;
                                r_led_data <= r_shift[NBITS-2];
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_led_clock <= 1'b0;
                    r_led_data  <= 1'b0;
                    if (r_latch_cnt == LAT_LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_pixel_ready <= 1'b0;
                    r_led_clock   <= 1'b0;
                    r_led_data    <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_strip_driver.sv
// Bench for led_strip_driver: a WS2801 receiver model shifts in ledData on
// each ledClock rising edge and compares whole pixels against a queue of
// expected scaled words pushed at each pixel handshake.
module tb_led_strip_driver;

    localparam int LEDS  = 2;
    localparam int CH    = 3;
    localparam int BPC   = 8;
    localparam int CD    = 2;
    localparam int LAT   = 20;
    localparam int NB    = CH * BPC;
    localparam int FRAME = LEDS * (1 + 2 * CD * NB) + LAT + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    brightness = 8'h00;
    logic [23:0]   pixelData = 24'h000000;
    logic          pixelValid = 1'b0;
    logic          pixelReady;
    logic          ledClock;
    logic          ledData;
    logic          busy;
    logic          done;
    logic          underrun;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [23:0]   exp_q[$];

    led_strip_driver #(
        .LEDS(LEDS), .CHANNELS(CH), .BPC(BPC), .CLK_DIV(CD), .LATCH_CYCLES(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .brightness(brightness),
        .pixelData(pixelData), .pixelValid(pixelValid), .pixelReady(pixelReady),
        .ledClock(ledClock), .ledData(ledData), .busy(busy), .done(done),
        .underrun(underrun)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] scale_px(input logic [23:0] p, input logic [7:0] br);
        int c, v;
        logic [23:0] r;
        r = 24'h000000;
        for (int k = 0; k < 3; k++) begin
            c = (int'(p) >> (16 - 8 * k)) & 255;
            v = (c * (int'(br) + 1)) / 256;
            r[23 - 8 * k -: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic run_frame(input string name, input logic [7:0] br, input logic [23:0] p0,
                             input logic [23:0] p1, input int stall2, input bit poke);
        logic [23:0] pix[2];
        logic [23:0] sr = 24'h000000;
        logic [31:0] expw;
        logic        prev_lclk = 1'b0;
        int idx = 0, stalled = 0, edges = 0, bits = 0, dones = 0, done_cyc = 0;
        int hs = 0, lclk_bad = 0, zero_bad = 0;
        pix[0] = p0;
        pix[1] = p1;
        brightness = br;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({name, " busy_T1"}, 32'(busy), 32'd1);
        check_eq({name, " ready_T1"}, 32'(pixelReady), 32'd1);
        check_eq({name, " underrun_T1"}, 32'(underrun), 32'd0);
        for (int cyc = 1; cyc <= FRAME + stall2 + 40; cyc++) begin
            if (ledClock && !prev_lclk) begin
                edges++;
                sr = {sr[22:0], ledData};
                if (br == 8'h00 && ledData !== 1'b0) zero_bad++;
                bits++;
                if (bits == NB) begin
                    bits = 0;
                    expw = 32'hFFFF_FFFF;
                    if (exp_q.size() > 0) expw = {8'h00, exp_q.pop_front()};
                    check_eq({name, " pixel"}, {8'h00, sr}, expw);
                end
            end
            prev_lclk = ledClock;
            if (pixelReady && ledClock) lclk_bad++;
            if (done) begin
                dones++;
                done_cyc = cyc;
                check_eq({name, " busy_at_done"}, 32'(busy), 32'd0);
            end
            if (idx < 2) begin
                if (idx == 1 && stalled < stall2 && pixelReady) begin
                    pixelValid = 1'b0;
                    stalled++;
                    if (stalled == 8) check_eq({name, " underrun_early"}, 32'(underrun), 32'd0);
                end else begin
                    pixelValid = 1'b1;
                    pixelData = pix[idx];
                    if (pixelReady) begin
                        exp_q.push_back(scale_px(pix[idx], br));
                        hs++;
                        if (idx == 1 && stall2 > 0)
                            check_eq({name, " underrun_set"}, 32'(underrun), 32'(stall2 >= LAT / 2));
                        idx++;
                    end
                end
            end else begin
                // Junk offered outside FETCH must never be taken.
                pixelValid = 1'b1;
                pixelData = 24'hA5A5A5;
                if (pixelReady) hs++;
            end
            start = poke && (cyc == 50 || cyc == FRAME - 10);
            if (dones > 0 && cyc >= done_cyc + 5) break;
            @(negedge clk);
        end
        start = 1'b0;
        pixelValid = 1'b0;
        check_eq({name, " done_count"}, 32'(dones), 32'd1);
        check_eq({name, " done_cycle"}, 32'(done_cyc), 32'(FRAME + stall2));
        check_eq({name, " clk_edges"}, 32'(edges), 32'(LEDS * NB));
        check_eq({name, " handshakes"}, 32'(hs), 32'd2);
        check_eq({name, " queue_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({name, " lclk_in_fetch"}, 32'(lclk_bad), 32'd0);
        check_eq({name, " zero_data"}, 32'(zero_bad), 32'd0);
        check_eq({name, " busy_after"}, 32'(busy), 32'd0);
        check_eq({name, " ready_after"}, 32'(pixelReady), 32'd0);
        check_eq({name, " underrun_after"}, 32'(underrun), 32'(stall2 >= LAT / 2));
        exp_q.delete();
    endtask

    initial begin
        #12;
        check_eq("rst pixelReady", 32'(pixelReady), 32'd0);
        check_eq("rst ledClock", 32'(ledClock), 32'd0);
        check_eq("rst ledData", 32'(ledData), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_frame("full", 8'hFF, 24'hFFDF00, 24'h3700FF, 0, 1'b0);
        run_frame("half", 8'h7F, 24'hFF8002, 24'h00FF80, 0, 1'b0);
        run_frame("zero", 8'h00, 24'h123456, 24'hFFFFFF, 0, 1'b0);
        run_frame("stall", 8'hFF, 24'h0F0F0F, 24'hF0F0F0, 15, 1'b0);
        check_eq("underrun sticky idle", 32'(underrun), 32'd1);
        run_frame("poke", 8'hFF, 24'hA5C35A, 24'h5A3CA5, 0, 1'b1);

        // Abandon a frame mid-SHIFT with an asynchronous reset.
        brightness = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pixelValid = 1'b1;
        pixelData = 24'hC3C3C3;
        repeat (40) @(negedge clk);
        check_eq("pre_rst busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("async pixelReady", 32'(pixelReady), 32'd0);
        check_eq("async ledClock", 32'(ledClock), 32'd0);
        check_eq("async ledData", 32'(ledData), 32'd0);
        check_eq("async busy", 32'(busy), 32'd0);
        check_eq("async done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pixelValid = 1'b0;
        @(negedge clk);
        check_eq("post_rst busy", 32'(busy), 32'd0);
        check_eq("post_rst ready", 32'(pixelReady), 32'd0);
        run_frame("after_rst", 8'hFF, 24'h814224, 24'h7E7E7E, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_strip_driver.md
# led_strip_driver

Parametrised, synthesizable serial driver for chains of WS2801-style clocked LED controllers, the next generation of the ColorChordTop LED output driver. It accepts one pixel per valid/ready handshake, applies a global brightness scale, shifts every channel out MSB-first on ledClock/ledData, and then holds the line idle for the controller latch interval. It sits between the colour-generation stage and the board pins. LED count, channel count, bits per channel, serial clock rate and latch time are all parameters.

## Interface
- LEDS, 50: pixels per frame (≥1)
- CHANNELS, 3: colour channels per pixel (≥1)
- BPC, 8: bits per channel (2..16)
- CLK_DIV, 4: clk cycles per ledClock phase; low phase = high phase = CLK_DIV (≥1)
- LATCH_CYCLES, 6250: clk cycles of idle-low after the last bit (500 µs at 12.5 MHz)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- brightness  in  BPC  global scale, sampled on the cycle start is accepted
- pixelData  in  CHANNELS*BPC  channel 0 in the MSBs, sent first
- pixelValid  in  1  pixelData valid
- pixelReady  out  1  driver can accept a pixel
- ledClock  out  1  serial clock to the strip
- ledData  out  1  serial data to the strip
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of latch
- underrun  out  1  sticky: a pixel stall reached LATCH_CYCLES/2 cycles; cleared on accepted start

## Operation
- Reset (rst low, asynchronous): state IDLE; pixelReady, ledClock, ledData, busy, done, underrun all 0; all counters 0.
- IDLE: busy=0. start=1 → latch brightness into bReg, pixel counter=0, clear underrun → FETCH.
- FETCH: pixelReady=1, ledClock=0, ledData holds its last value. pixelValid&pixelReady → each channel c becomes (c*(bReg+1))>>BPC, truncated to BPC bits; the scaled word loads the shift register → SHIFT. Stall counter increments per FETCH cycle without a handshake; on reaching LATCH_CYCLES/2, set underrun (state unchanged).
- SHIFT: CHANNELS*BPC bits, MSB first. Each bit is CLK_DIV cycles with ledClock=0 and ledData=bit, then CLK_DIV cycles with ledClock=1 and ledData held. After the high phase of the last bit: if pixel counter < LEDS-1, increment it → FETCH; otherwise → LATCH.
- LATCH: ledClock=0, ledData=0 for LATCH_CYCLES cycles → DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle → IDLE.
- start while busy is ignored. pixelValid outside FETCH is ignored; pixelReady=0 there.
- bReg=all-ones is an identity scale. bReg=0 gives c>>BPC, which is 0 for every c.
- Product width is 2*BPC before the shift; no saturation is needed.

## Timing
- All outputs are registered.
- Accepted start at cycle T: busy=1 and pixelReady=1 from T+1.
- Handshake at cycle H: pixelReady=0 from H+1. The first bit appears on ledData at H+1 with ledClock=0. The first rising edge of ledClock is at H+1+CLK_DIV.
- Per pixel: 2*CLK_DIV*CHANNELS*BPC cycles of SHIFT, plus at least 1 FETCH cycle.
- With pixelValid held high, the frame takes LEDS*(1+2*CLK_DIV*CHANNELS*BPC) + LATCH_CYCLES + 1 cycles, measured from the first FETCH cycle to done inclusive.
- rst asserted mid-frame: immediate return to IDLE with all outputs 0; the partial frame is abandoned. A stall in FETCH is not itself a latch; the downstream strip may latch on it anyway, which is why underrun exists.

## Test plan
- Reset mid-SHIFT (rst low at an arbitrary cycle) → all outputs 0 asynchronously; IDLE after release; a following start runs a full, clean frame.
- LEDS=2, CHANNELS=3, BPC=8, CLK_DIV=2, LATCH_CYCLES=20, brightness=FF, pixels FFDF00 then 3700FF, pixelValid always high → WS2801 model chain reads FFDF00 / 3700FF; exactly 48 ledClock rising edges; done pulses once at the cycle count given by the formula above.
- Same setup with brightness=7F and pixel FF8002 → shifted word 7F4001 (FF*80>>8=7F, 80*80>>8=40, 02*80>>8=01).
- brightness=00 with any pixels → ledData=0 at every rising edge; done still pulses.
- pixelValid withheld for 15 cycles before the second pixel (LATCH_CYCLES=20) → underrun=1 at the 10th stall cycle; ledClock stays low throughout the stall; the frame completes; underrun clears on the next accepted start.
- start pulsed during SHIFT and during LATCH → ignored: no extra pixelReady and no restart; exactly one done per accepted start.
